// File: rtl/dl_sequencer.sv
// dl_sequencer: routes the HPS ioctl download stream to the ROM write FIFO, the mod and
// DIP registers, and holds the game core in reset around a ROM load.
module dl_sequencer #(
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_CYC   = 1024
) (
  input  logic              i_clk_sys,
  input  logic              i_reset_n,
  input  logic              i_ioctl_download,
  input  logic [7:0]        i_ioctl_index,
  input  logic              i_ioctl_wr,
  input  logic [24:0]       i_ioctl_addr,
  input  logic [7:0]        i_ioctl_dout,
  output logic              o_ioctl_wait,
  output logic [ADDR_W-1:0] o_rom_addr,
  output logic [7:0]        o_rom_data,
  output logic              o_rom_wr,
  input  logic              i_rom_ready,
  output logic              o_mod_sbag,
  output logic              o_mod_pick,
  output logic              o_mod_squa,
  output logic [63:0]       o_dipsw,
  output logic              o_core_reset,
  output logic              o_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int HC_W  = $clog2(HOLD_CYC + 1);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYC - 1);

  logic [1:0]        r_state;
  logic [HC_W-1:0]   r_hold_cnt;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];
  logic [7:0]        r_mem_data [FIFO_DEPTH];
  logic              r_overflow;
  logic              r_mod_sbag;
  logic              r_mod_pick;
  logic              r_mod_squa;
  logic [63:0]       r_dipsw;

  logic w_rom_sel;
  logic w_addr_ok;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_start;

  assign w_rom_sel = (i_ioctl_index == 8'd0);
  assign w_addr_ok = ((i_ioctl_addr >> ADDR_W) == 25'd0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == {CNT_W{1'b0}});
  // Full is judged on the registered count, so a same-cycle pop never frees room for a push.
  assign w_push    = i_ioctl_wr & w_rom_sel & (r_state == S_LOAD) & w_addr_ok & ~w_full;
  assign w_pop     = ~w_empty & i_rom_ready;
  assign w_start   = i_ioctl_download & w_rom_sel;

  // Load/drain/hold/run sequencing with the post-load reset extension counter.
  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_HOLD;
      r_hold_cnt <= {HC_W{1'b0}};
    end else if (w_start) begin
      r_state    <= S_LOAD;
      r_hold_cnt <= {HC_W{1'b0}};
    end else begin
      case (r_state)
        S_LOAD: begin
          if (!i_ioctl_download) r_state <= S_DRAIN;
          else r_state <= S_LOAD;
        end
        S_DRAIN: begin
          if (w_empty) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= {HC_W{1'b0}};
          end else begin
            r_state <= S_DRAIN;
          end
        end
        S_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) r_state <= S_RUN;
          else r_hold_cnt <= r_hold_cnt + HC_W'(1);
        end
        S_RUN:   r_state <= S_RUN;
        default: r_state <= S_HOLD;
      endcase
    end
  end

  // ROM write FIFO storage, pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count    <= {CNT_W{1'b0}};
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_addr[i] <= {ADDR_W{1'b0}};
        r_mem_data[i] <= 8'd0;
      end
    end else begin
      if (w_push) begin
        r_mem_addr[r_wr_ptr] <= i_ioctl_addr[ADDR_W-1:0];
        r_mem_data[r_wr_ptr] <= i_ioctl_dout;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (i_ioctl_wr & w_rom_sel & w_full) r_overflow <= 1'b1;
      else r_overflow <= r_overflow;
    end
  end

  // Mod byte decode and DIP bank writes; both ignore the sequencer state.
  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mod_sbag <= 1'b0;
      r_mod_pick <= 1'b0;
      r_mod_squa <= 1'b0;
      r_dipsw    <= 64'd0;
    end else begin
      if (i_ioctl_wr && (i_ioctl_index == 8'd1) && (i_ioctl_addr == 25'd0)) begin
        r_mod_sbag <= (i_ioctl_dout == 8'd1);
        r_mod_pick <= (i_ioctl_dout == 8'd2);
        r_mod_squa <= (i_ioctl_dout == 8'd3);
      end
      if (i_ioctl_wr && (i_ioctl_index == 8'd254) && (i_ioctl_addr[24:3] == 22'd0))
        r_dipsw[{i_ioctl_addr[2:0], 3'b000} +: 8] <= i_ioctl_dout;
    end
  end

  assign o_ioctl_wait = w_full;
  assign o_rom_wr     = ~w_empty;
  assign o_rom_addr   = r_mem_addr[r_rd_ptr];
  assign o_rom_data   = r_mem_data[r_rd_ptr];
  assign o_core_reset = (r_state != S_RUN);
  assign o_overflow   = r_overflow;
  assign o_mod_sbag   = r_mod_sbag;
  assign o_mod_pick   = r_mod_pick;
  assign o_mod_squa   = r_mod_squa;
  assign o_dipsw      = r_dipsw;

endmodule

// File: tb/tb_dl_sequencer.sv
// Self-checking bench for dl_sequencer: per-feature tasks plus a ROM-write scoreboard.
module tb_dl_sequencer;

  localparam int ADDR_W = 17;
  localparam int DEPTH  = 4;
  localparam int HOLD   = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              o_ioctl_wait;
  logic [ADDR_W-1:0] o_rom_addr;
  logic [7:0]        o_rom_data;
  logic              o_rom_wr;
  logic              rom_ready;
  logic              o_mod_sbag;
  logic              o_mod_pick;
  logic              o_mod_squa;
  logic [63:0]       o_dipsw;
  logic              o_core_reset;
  logic              o_overflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [ADDR_W+7:0] q [$];

  always #5 clk = ~clk;

  dl_sequencer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .HOLD_CYC(HOLD)) dut (
    .i_clk_sys(clk), .i_reset_n(reset_n), .i_ioctl_download(ioctl_download),
    .i_ioctl_index(ioctl_index), .i_ioctl_wr(ioctl_wr), .i_ioctl_addr(ioctl_addr),
    .i_ioctl_dout(ioctl_dout), .o_ioctl_wait(o_ioctl_wait), .o_rom_addr(o_rom_addr),
    .o_rom_data(o_rom_data), .o_rom_wr(o_rom_wr), .i_rom_ready(rom_ready),
    .o_mod_sbag(o_mod_sbag), .o_mod_pick(o_mod_pick), .o_mod_squa(o_mod_squa),
    .o_dipsw(o_dipsw), .o_core_reset(o_core_reset), .o_overflow(o_overflow)
  );

  // One clock; any ROM write transferring this cycle is checked against the scoreboard.
  task automatic step();
    logic [ADDR_W+7:0] e;
    @(negedge clk);
    if (o_rom_wr && rom_ready) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL rom_write_unexpected addr=%h data=%h expected no write", o_rom_addr, o_rom_data);
      end else begin
        e = q.pop_front();
        if ({o_rom_addr, o_rom_data} !== e) begin
          n_fail++;
          $display("FAIL rom_write_order got addr=%h data=%h expected addr=%h data=%h",
                   o_rom_addr, o_rom_data, e[ADDR_W+7:8], e[7:0]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] idx, input logic [24:0] addr,
                        input logic [7:0] d, input bit exp_push);
    ioctl_index = idx;
    ioctl_addr  = addr;
    ioctl_dout  = d;
    ioctl_wr    = 1'b1;
    if (exp_push) q.push_back({addr[ADDR_W-1:0], d});
    step();
    ioctl_wr = 1'b0;
  endtask

  task automatic measure_hold(input string name);
    int c;
    bit saw_wr;
    c = 0;
    saw_wr = 1'b0;
    while (o_core_reset && c < HOLD + 20) begin
      if (o_rom_wr) saw_wr = 1'b1;
      c++;
      step();
    end
    n_tests++;
    if (c != HOLD) begin
      n_fail++;
      $display("FAIL %s core_reset high for %0d cycles expected %0d", name, c, HOLD);
    end
    n_tests++;
    if (saw_wr) begin
      n_fail++;
      $display("FAIL %s_rom_wr rom_wr seen during hold expected 0", name);
    end
  endtask

  task automatic finish_download();
    int c;
    c = 0;
    ioctl_download = 1'b0;
    while (o_core_reset && c < HOLD + 30) begin
      c++;
      step();
    end
    n_tests++;
    if (o_core_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL finish_download core_reset=%b expected 0 within budget", o_core_reset);
    end
  endtask

  task automatic test_reset();
    step();
    step();
    n_tests++;
    if ({o_core_reset, o_rom_wr, o_ioctl_wait, o_overflow} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctrl got core_reset/rom_wr/wait/ovf=%b expected 1000",
               {o_core_reset, o_rom_wr, o_ioctl_wait, o_overflow});
    end
    n_tests++;
    if ({o_mod_sbag, o_mod_pick, o_mod_squa} !== 3'b000 || o_dipsw !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_regs got mod=%b dipsw=%h expected 000 and 0",
               {o_mod_sbag, o_mod_pick, o_mod_squa}, o_dipsw);
    end
    reset_n = 1'b1;
    measure_hold("reset_hold");
  endtask

  task automatic test_rom_load();
    logic [7:0] dat [3];
    dat[0] = 8'hA5;
    dat[1] = 8'h5A;
    dat[2] = 8'h3C;
    rom_ready      = 1'b1;
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    step();
    n_tests++;
    if (o_core_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL load_core_reset got %b expected 1", o_core_reset);
    end
    for (int i = 0; i < 3; i++) begin
      strobe(8'd0, 25'(i), dat[i], 1'b1);
      n_tests++;
      if (o_rom_wr !== 1'b1 || o_rom_addr !== ADDR_W'(i) || o_rom_data !== dat[i]) begin
        n_fail++;
        $display("FAIL load_latency byte %0d got wr=%b addr=%h data=%h expected 1 %h %h",
                 i, o_rom_wr, o_rom_addr, o_rom_data, i, dat[i]);
      end
      step();
      n_tests++;
      if (o_rom_wr !== 1'b0) begin
        n_fail++;
        $display("FAIL load_pulse byte %0d rom_wr=%b expected 0", i, o_rom_wr);
      end
    end
    ioctl_download = 1'b0;
    step();
    step();
    measure_hold("load_hold");
  endtask

  task automatic test_backpressure();
    int c;
    rom_ready      = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      strobe(8'd0, 25'h100 + 25'(i), 8'hC0 + 8'(i), i < DEPTH);
      if (i == 2 || i == 3) begin
        n_tests++;
        if (o_ioctl_wait !== (i == 3) || o_overflow !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_wait after strobe %0d got wait=%b ovf=%b expected %b 0",
                   i + 1, o_ioctl_wait, o_overflow, i == 3);
        end
      end
    end
    n_tests++;
    if (o_overflow !== 1'b1 || o_ioctl_wait !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_overflow got ovf=%b wait=%b expected 1 1", o_overflow, o_ioctl_wait);
    end
    rom_ready = 1'b1;
    step();
    n_tests++;
    if (o_ioctl_wait !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_wait_drop got %b expected 0", o_ioctl_wait);
    end
    c = 0;
    while (o_rom_wr && c < 10) begin
      c++;
      step();
    end
    n_tests++;
    if (q.size() != 0 || o_rom_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain got %0d pending rom_wr=%b expected 0 0", q.size(), o_rom_wr);
    end
    finish_download();
  endtask

  task automatic test_range_dip();
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    step();
    strobe(8'd0, 25'h20000, 8'h66, 1'b0);
    n_tests++;
    if (o_rom_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL range_drop rom_wr=%b expected 0", o_rom_wr);
    end
    finish_download();
    strobe(8'd254, 25'd5, 8'h7E, 1'b0);
    n_tests++;
    if (o_dipsw !== 64'h0000_7E00_0000_0000) begin
      n_fail++;
      $display("FAIL dip_byte5 got %h expected 00007e0000000000", o_dipsw);
    end
    strobe(8'd254, 25'd8, 8'hFF, 1'b0);
    strobe(8'd254, 25'd0, 8'h11, 1'b0);
    n_tests++;
    if (o_dipsw !== 64'h0000_7E00_0000_0011 || o_core_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL dip_range got %h core_reset=%b expected 00007e0000000011 0",
               o_dipsw, o_core_reset);
    end
  endtask

  task automatic test_mod();
    strobe(8'd1, 25'd0, 8'h03, 1'b0);
    n_tests++;
    if ({o_mod_sbag, o_mod_pick, o_mod_squa} !== 3'b001 || o_core_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL mod_squa got mod=%b core_reset=%b expected 001 0",
               {o_mod_sbag, o_mod_pick, o_mod_squa}, o_core_reset);
    end
    strobe(8'd1, 25'd0, 8'h01, 1'b0);
    strobe(8'd1, 25'd1, 8'h02, 1'b0);
    n_tests++;
    if ({o_mod_sbag, o_mod_pick, o_mod_squa} !== 3'b100) begin
      n_fail++;
      $display("FAIL mod_sbag got mod=%b expected 100", {o_mod_sbag, o_mod_pick, o_mod_squa});
    end
  endtask

  task automatic test_reset_mid_load();
    rom_ready      = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    step();
    strobe(8'd0, 25'h10, 8'h01, 1'b1);
    strobe(8'd0, 25'h11, 8'h02, 1'b1);
    reset_n = 1'b0;
    #1;
    q.delete();
    n_tests++;
    if ({o_rom_wr, o_ioctl_wait, o_core_reset, o_overflow} !== 4'b0010 ||
        o_dipsw !== 64'd0 || {o_mod_sbag, o_mod_pick, o_mod_squa} !== 3'b000) begin
      n_fail++;
      $display("FAIL midload_reset got wr/wait/crst/ovf=%b dipsw=%h mod=%b expected 0010 0 000",
               {o_rom_wr, o_ioctl_wait, o_core_reset, o_overflow}, o_dipsw,
               {o_mod_sbag, o_mod_pick, o_mod_squa});
    end
    ioctl_download = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    measure_hold("midload_hold");
  endtask

  task automatic test_restart_in_hold();
    rom_ready      = 1'b1;
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    step();
    strobe(8'd0, 25'h42, 8'h99, 1'b1);
    step();
    ioctl_download = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) step();
    ioctl_download = 1'b1;
    step();
    strobe(8'd0, 25'h43, 8'h77, 1'b1);
    n_tests++;
    if (o_rom_wr !== 1'b1 || o_rom_addr !== ADDR_W'(17'h43) || o_core_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_load got wr=%b addr=%h crst=%b expected 1 43 1",
               o_rom_wr, o_rom_addr, o_core_reset);
    end
    step();
    ioctl_download = 1'b0;
    step();
    step();
    measure_hold("restart_hold");
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty got %0d pending expected 0", q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = 25'd0;
    ioctl_dout     = 8'd0;
    rom_ready      = 1'b0;
    test_reset();
    test_rom_load();
    test_backpressure();
    test_range_dip();
    test_mod();
    test_reset_mid_load();
    test_restart_in_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
